// File: rtl/bank_ch_resp_route.sv
// Per-bank return-path router: records granted channel IDs in order and steers each
// in-order bank response to its channel. Optional check logic: BANK_CH_RESP_ROUTE_CHK_EN.
module bank_ch_resp_route #(
  parameter int unsigned ORDER_DEPTH = 4,
  parameter int unsigned DATA_W      = 64,
  localparam int unsigned CNT_W      = $clog2(ORDER_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              grant_valid_i,
  input  logic [1:0]        grant_ch_id_i,
  output logic              order_full_o,
  output logic [CNT_W-1:0]  order_cnt_o,
  input  logic              bank_resp_valid_i,
  input  logic [DATA_W-1:0] bank_resp_data_i,
  output logic              bank_resp_ready_o,
  output logic [2:0]        ch_resp_valid_o,
  output logic [DATA_W-1:0] ch_resp_data_o,
  input  logic [2:0]        ch_resp_ready_i,
  output logic              resp_err_o
);

  localparam int unsigned PTR_W  = $clog2(ORDER_DEPTH);
  localparam int unsigned CH_W   = 2;
  localparam int unsigned NUM_CH = 3;

  logic [CH_W-1:0]   order_mem [ORDER_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              out_vld;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;
  logic out_take_c;

  assign full_c  = (count == CNT_W'(ORDER_DEPTH));
  assign empty_c = (count == '0);

  // Held response leaves when its channel is ready; an illegal channel 3 drains unconditionally.
  always_comb begin
    out_take_c = 1'b0;
    if (out_vld) begin
      case (out_ch)
        2'd0:    out_take_c = ch_resp_ready_i[0];
        2'd1:    out_take_c = ch_resp_ready_i[1];
        2'd2:    out_take_c = ch_resp_ready_i[2];
        default: out_take_c = 1'b1;
      endcase
    end
  end

  assign bank_resp_ready_o = !empty_c && (!out_vld || out_take_c);
  assign push_c            = grant_valid_i && !full_c;
  assign pop_c             = bank_resp_valid_i && bank_resp_ready_o;

  // Order FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_c) wptr <= wptr + PTR_W'(1);
      if (pop_c)  rptr <= rptr + PTR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (pop_c && !push_c) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) order_mem[wptr] <= grant_ch_id_i;
  end

  // Single registered output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld  <= 1'b0;
      out_ch   <= '0;
      out_data <= '0;
    end else if (pop_c) begin
      out_vld  <= 1'b1;
      out_ch   <= order_mem[rptr];
      out_data <= bank_resp_data_i;
    end else if (out_take_c) begin
      out_vld  <= 1'b0;
    end
  end

  assign ch_resp_valid_o = out_vld ? (NUM_CH'(1) << out_ch) : '0;
  assign ch_resp_data_o  = out_data;
  assign order_full_o    = full_c;
  assign order_cnt_o     = count;

`ifdef BANK_CH_RESP_ROUTE_CHK_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((grant_valid_i && full_c) ||
                 (bank_resp_valid_i && empty_c) ||
                 (grant_valid_i && (grant_ch_id_i == 2'd3))) begin
      err_q <= 1'b1;
    end
  end

  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bank_ch_resp_route.sv
// Scoreboard bench for bank_ch_resp_route: queue-based reference model plus an
// independent monitor that checks every delivered channel response.
module tb_bank_ch_resp_route;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          grant_valid_i;
  logic [1:0]    grant_ch_id_i;
  logic          order_full_o;
  logic [CW-1:0] order_cnt_o;
  logic          bank_resp_valid_i;
  logic [DW-1:0] bank_resp_data_i;
  logic          bank_resp_ready_o;
  logic [2:0]    ch_resp_valid_o;
  logic [DW-1:0] ch_resp_data_o;
  logic [2:0]    ch_resp_ready_i;
  logic          resp_err_o;

  bank_ch_resp_route #(.ORDER_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .grant_valid_i(grant_valid_i), .grant_ch_id_i(grant_ch_id_i),
    .order_full_o(order_full_o), .order_cnt_o(order_cnt_o),
    .bank_resp_valid_i(bank_resp_valid_i), .bank_resp_data_i(bank_resp_data_i),
    .bank_resp_ready_o(bank_resp_ready_o),
    .ch_resp_valid_o(ch_resp_valid_o), .ch_resp_data_o(ch_resp_data_o),
    .ch_resp_ready_i(ch_resp_ready_i), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } resp_t;

  int checks = 0;
  int failures = 0;

  // Reference model: order queue of channel IDs and the one held output slot
  logic [1:0]    order_q [$];
  resp_t         exp_q [$];
  logic          held_vld;
  logic [1:0]    held_ch;
  logic [DW-1:0] held_data;
  logic          err_m;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input logic vld, input logic [1:0] ch);
    logic [2:0] v;
    v = 3'b000;
    if (vld && ch < 2'd3) v[ch] = 1'b1;
    return v;
  endfunction

  task automatic check_regs();
    chk("order_cnt", DW'(order_cnt_o), DW'(order_q.size()));
    chk("order_full", DW'(order_full_o), DW'(order_q.size() == DEPTH));
    chk("ch_valid", DW'(ch_resp_valid_o), DW'(onehot(held_vld, held_ch)));
    chk("ch_data", ch_resp_data_o, held_data);
    chk("resp_err", DW'(resp_err_o), DW'(err_m));
  endtask

  // One clock of stimulus: check state, drive inputs, check ready, advance model
  task automatic cycle(input logic gv, input logic [1:0] gch, input logic bv,
                       input logic [DW-1:0] bd, input logic [2:0] rdy);
    int  sz;
    logic exp_rdy;
    logic [1:0] ch;
    @(posedge clk_i); #1;
    check_regs();
    grant_valid_i = gv; grant_ch_id_i = gch;
    bank_resp_valid_i = bv; bank_resp_data_i = bd; ch_resp_ready_i = rdy;
    sz = order_q.size();
    exp_rdy = (sz != 0) && (!held_vld || held_ch == 2'd3 || rdy[held_ch]);
    #1;
    chk("bank_ready", DW'(bank_resp_ready_o), DW'(exp_rdy));
`ifdef BANK_CH_RESP_ROUTE_CHK_EN
    if ((gv && sz == DEPTH) || (bv && sz == 0) || (gv && gch == 2'd3)) err_m = 1'b1;
`endif
    if (bv && exp_rdy) begin
      ch = order_q.pop_front();
      held_vld = 1'b1; held_ch = ch; held_data = bd;
      if (ch != 2'd3) exp_q.push_back('{ch: ch, data: bd});
    end else if (held_vld && (held_ch == 2'd3 || rdy[held_ch])) begin
      held_vld = 1'b0;
    end
    if (gv && sz != DEPTH) order_q.push_back(gch);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    grant_valid_i = 1'b0; grant_ch_id_i = 2'd0;
    bank_resp_valid_i = 1'b0; bank_resp_data_i = '0; ch_resp_ready_i = 3'b000;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    order_q.delete(); exp_q.delete();
    held_vld = 1'b0; held_ch = 2'd0; held_data = '0; err_m = 1'b0;
    chk("rst_ready", DW'(bank_resp_ready_o), DW'(0));
    check_regs();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every completed channel handshake must match the next scoreboard entry
  initial begin
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i && ((ch_resp_valid_o & ch_resp_ready_i) != 3'b000)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", DW'(ch_resp_valid_o), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("mon_ch", DW'(ch_resp_valid_o), DW'(onehot(1'b1, e.ch)));
          chk("mon_data", ch_resp_data_o, e.data);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    int n;
    rst_i = 1'b1;
    do_reset();

    // In-order routing of grants 2,0,1
    d0 = 64'hD0D0_0000_0000_00D0; d1 = 64'hD1D1_1111_1111_11D1; d2 = 64'hD2D2_2222_2222_22D2;
    cycle(1, 2'd2, 0, '0, 3'b111);
    cycle(1, 2'd0, 0, '0, 3'b111);
    cycle(1, 2'd1, 0, '0, 3'b111);
    cycle(0, 2'd0, 1, d0, 3'b111);
    chk("cnt_after_3_grants", DW'(order_cnt_o), DW'(3));
    cycle(0, 2'd0, 1, d1, 3'b111);
    chk("first_route", DW'(ch_resp_valid_o), DW'(3'b100));
    cycle(0, 2'd0, 1, d2, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);

    // Fill, then a dropped grant while full
    for (int i = 0; i < 4; i++) cycle(1, 2'(i % 3), 0, '0, 3'b111);
    cycle(1, 2'd1, 0, '0, 3'b111);
    chk("full_flag", DW'(order_full_o), DW'(1));
    cycle(1, 2'd1, 1, rnd_data(), 3'b111);
    for (int i = 0; i < 5; i++) cycle(0, 2'd0, 1, rnd_data(), 3'b111);

    // Backpressure on channel 1 with non-addressed readies high
    do_reset();
    cycle(1, 2'd1, 0, '0, 3'b111);
    cycle(1, 2'd0, 0, '0, 3'b111);
    cycle(0, 2'd0, 1, 64'hBEEF_0001, 3'b101);
    for (int i = 0; i < 3; i++) cycle(0, 2'd0, 1, 64'hBEEF_0002, 3'b101);
    chk("bp_hold_valid", DW'(ch_resp_valid_o), DW'(3'b010));
    cycle(0, 2'd0, 1, 64'hBEEF_0002, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);

    // Push/pop at count 2 across two pointer wraps
    cycle(1, 2'd2, 0, '0, 3'b111);
    cycle(1, 2'd0, 0, '0, 3'b111);
    for (int i = 0; i < 10; i++) cycle(1, 2'((i + 1) % 3), 1, rnd_data(), 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);
    chk("cnt_steady_2", DW'(order_cnt_o), DW'(2));
    cycle(0, 2'd0, 1, rnd_data(), 3'b111);
    cycle(0, 2'd0, 1, rnd_data(), 3'b111);

    // Bank response with empty FIFO
    cycle(0, 2'd0, 1, 64'hDEAD, 3'b111);
    cycle(0, 2'd0, 1, 64'hDEAD, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);

    // Reset with outstanding entries and a held response
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 2'(i % 3), 0, '0, 3'b000);
    cycle(0, 2'd0, 1, 64'h5A5A, 3'b000);
    cycle(0, 2'd0, 0, '0, 3'b000);
    do_reset();
    cycle(1, 2'd0, 0, '0, 3'b111);
    cycle(0, 2'd0, 1, 64'hC0C0, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);
    chk("post_rst_route", DW'(ch_resp_valid_o), DW'(3'b001));
    cycle(0, 2'd0, 0, '0, 3'b111);

    // Randomised traffic including occasional illegal channel 3
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), rnd_data(), 3'($urandom));
    end

    // Drain with a bounded cycle budget
    n = 0;
    while ((order_q.size() != 0 || held_vld) && n < 50) begin
      cycle(0, 2'd0, 1, rnd_data(), 3'b111);
      n++;
    end
    cycle(0, 2'd0, 0, '0, 3'b111);
    cycle(0, 2'd0, 0, '0, 3'b111);
    chk("drain_budget", DW'(n < 50), DW'(1));
    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
